// File: rtl/rom_sequencer.sv
// Instruction fetch/issue unit: walks a combinational program ROM from FIRST_ADDR and
// issues decoded words over valid/ready. Optional macro ROM_SEQ_PREFETCH_EN enables
// one-instruction-per-cycle prefetch.
module rom_sequencer #(
    parameter int                ADDR_W     = 3,
    parameter int                INST_W     = 19,
    parameter logic [INST_W-1:0] END_WORD   = 19'h7f000,
    parameter int                FIRST_ADDR = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              flush,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_dout,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [2:0]        inst_op,
    output logic [3:0]        inst_rd,
    output logic [3:0]        inst_rs,
    output logic [3:0]        inst_rt,
    output logic [7:0]        inst_imm,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              busy,
    output logic              done,
    output logic [2:0]        issued_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] FIRST_PC  = ADDR_W'(FIRST_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PC_ONE    = ADDR_W'(1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [INST_W-1:0]   r_instr;
    logic [2:0]          r_issued_cnt;

    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic [INST_W-1:0]   w_instr_nxt;
    logic [2:0]          w_cnt_nxt;
    logic [ADDR_W-1:0]   w_rom_addr;
    logic                w_handshake;
    logic                w_last_pc;

    assign w_handshake = (r_state == ISSUE) && inst_ready;
    assign w_last_pc   = (r_pc == LAST_ADDR);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_cnt_nxt   = r_issued_cnt;
        w_rom_addr  = '0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_pc_nxt    = FIRST_PC;
                    w_cnt_nxt   = 3'd0;
                    w_state_nxt = FETCH;
                end
            end

            FETCH: begin
                w_rom_addr  = r_pc;
                w_instr_nxt = rom_dout;
                w_state_nxt = (rom_dout == END_WORD) ? DONE : ISSUE;
            end

            ISSUE: begin
`ifdef ROM_SEQ_PREFETCH_EN
                // Clamp the prefetch at the last address so the ROM never sees a wrap to 0.
                w_rom_addr = w_last_pc ? r_pc : r_pc + PC_ONE;
                if (w_handshake) begin
                    w_cnt_nxt = r_issued_cnt + 3'd1;
                    if (w_last_pc || rom_dout == END_WORD) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_instr_nxt = rom_dout;
                        w_pc_nxt    = r_pc + PC_ONE;
                    end
                end
`else
                w_rom_addr = r_pc;
                if (w_handshake) begin
                    w_cnt_nxt = r_issued_cnt + 3'd1;
                    if (w_last_pc) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_pc_nxt    = r_pc + PC_ONE;
                        w_state_nxt = FETCH;
                    end
                end
`endif
            end

            DONE: begin
                w_rom_addr  = r_pc;
                w_state_nxt = IDLE;
            end

            default: w_state_nxt = IDLE;
        endcase

        // Abort wins over everything: a same-cycle handshake or start is discarded.
        if (flush) begin
            w_state_nxt = IDLE;
            w_pc_nxt    = r_pc;
            w_instr_nxt = r_instr;
            w_cnt_nxt   = r_issued_cnt;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_pc         <= '0;
            r_instr      <= '0;
            r_issued_cnt <= 3'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_instr      <= w_instr_nxt;
            r_issued_cnt <= w_cnt_nxt;
        end
    end

    assign rom_addr   = w_rom_addr;
    assign inst_valid = (r_state == ISSUE);
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign inst_op    = r_instr[18:16];
    assign inst_rd    = r_instr[15:12];
    assign inst_rs    = r_instr[11:8];
    assign inst_rt    = r_instr[7:4];
    assign inst_imm   = r_instr[7:0];
    assign inst_pc    = r_pc;
    assign issued_cnt = r_issued_cnt;

endmodule

// File: tb/tb_rom_sequencer.sv
// Directed bench for rom_sequencer (default build): ROM model, handshake monitor,
// immediate-assertion checks.
module tb_rom_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [2:0]  rom_addr;
    logic [18:0] rom_dout;
    logic        inst_valid;
    logic        inst_ready;
    logic [2:0]  inst_op;
    logic [3:0]  inst_rd;
    logic [3:0]  inst_rs;
    logic [3:0]  inst_rt;
    logic [7:0]  inst_imm;
    logic [2:0]  inst_pc;
    logic        busy;
    logic        done;
    logic [2:0]  issued_cnt;

    logic [18:0] rom [0:7];
    assign rom_dout = rom[rom_addr];

    rom_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .flush      (flush),
        .rom_addr   (rom_addr),
        .rom_dout   (rom_dout),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_op    (inst_op),
        .inst_rd    (inst_rd),
        .inst_rs    (inst_rs),
        .inst_rt    (inst_rt),
        .inst_imm   (inst_imm),
        .inst_pc    (inst_pc),
        .busy       (busy),
        .done       (done),
        .issued_cnt (issued_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Handshake monitor results
    int          n_hs;
    int          done_at;
    logic        saw_addr0;
    logic [2:0]  hs_pc   [16];
    logic [18:0] hs_word [16];
    int          hs_edge [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_prog_main();
        rom[0] = 19'h7f000; rom[1] = 19'h72006; rom[2] = 19'h73004; rom[3] = 19'h52230;
        rom[4] = 19'h32230; rom[5] = 19'h04240; rom[6] = 19'h7f000; rom[7] = 19'h7f000;
    endtask

    // Pulse start for one edge; returns at the sample point after that edge (edge E).
    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Cycle c means "sampled just after edge E+c"; a valid&ready sample completes at edge E+c+1.
    task automatic watch(input int max_c);
        n_hs      = 0;
        done_at   = -1;
        saw_addr0 = 1'b0;
        for (int c = 0; c < max_c; c++) begin
            if (busy && rom_addr == 3'd0) saw_addr0 = 1'b1;
            if (inst_valid && inst_ready && n_hs < 16) begin
                hs_pc[n_hs]   = inst_pc;
                hs_word[n_hs] = {inst_op, inst_rd, inst_rs, inst_rt, inst_imm[3:0]};
                hs_edge[n_hs] = c + 1;
                n_hs++;
            end
            if (done) begin
                done_at = c;
                break;
            end
            tick();
        end
        check("done_seen_within_budget", {31'd0, (done_at >= 0)}, 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        flush      = 1'b0;
        inst_ready = 1'b0;
        load_prog_main();
        #12;
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_busy",  {31'd0, busy},       32'd0);
        check("rst_done",  {31'd0, done},       32'd0);
        check("rst_addr",  {29'd0, rom_addr},   32'd0);
        check("rst_cnt",   {29'd0, issued_cnt}, 32'd0);
        check("rst_pc",    {29'd0, inst_pc},    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Main program, ready tied high
        inst_ready = 1'b1;
        do_start();
        check("t1_fetch_busy",  {31'd0, busy},       32'd1);
        check("t1_fetch_valid", {31'd0, inst_valid}, 32'd0);
        check("t1_fetch_addr",  {29'd0, rom_addr},   32'd1);
        watch(40);
        check("t1_n_issued", n_hs, 32'd5);
        for (int i = 0; i < 5; i++) check($sformatf("t1_pc%0d", i), {29'd0, hs_pc[i]}, i + 1);
        check("t1_w1_op",  {29'd0, hs_word[0][18:16]}, 32'd7);
        check("t1_w1_rd",  {28'd0, hs_word[0][15:12]}, 32'd2);
        check("t1_w1_imm", {24'd0, hs_word[0][7:0]},   32'h06);
        check("t1_w4_fields", {17'd0, hs_word[3][18:4]}, 32'h3223);
        check("t1_last_hs_edge", hs_edge[4], 32'd10);
        check("t1_done_at", done_at, 32'd11);
        check("t1_cnt", {29'd0, issued_cnt}, 32'd5);
        tick();
        check("t1_done_one_cycle", {31'd0, done}, 32'd0);
        check("t1_idle",  {31'd0, busy}, 32'd0);
        check("t1_cnt_hold", {29'd0, issued_cnt}, 32'd5);

        // Backpressure on PC 3
        do_start();           // after E: FETCH pc1
        tick();               // E+1: ISSUE pc1
        tick();               // E+2: handshake, FETCH pc2
        tick();               // E+3: ISSUE pc2
        tick();               // E+4: handshake, FETCH pc3
        inst_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("t2_stall_valid%0d", k), {31'd0, inst_valid}, 32'd1);
            check($sformatf("t2_stall_pc%0d", k),    {29'd0, inst_pc},    32'd3);
            check($sformatf("t2_stall_fld%0d", k),   {17'd0, inst_op, inst_rd, inst_rs, inst_rt}, 32'h5223);
            check($sformatf("t2_stall_imm%0d", k),   {24'd0, inst_imm},   32'h30);
            check($sformatf("t2_stall_cnt%0d", k),   {29'd0, issued_cnt}, 32'd2);
        end
        inst_ready = 1'b1;
        tick();
        check("t2_accept_cnt",   {29'd0, issued_cnt}, 32'd3);
        check("t2_accept_valid", {31'd0, inst_valid}, 32'd0);
        watch(40);
        check("t2_final_cnt", {29'd0, issued_cnt}, 32'd5);
        tick();

        // No end marker: run to the last address
        rom[0] = 19'h7f000; rom[1] = 19'h12345; rom[2] = 19'h23456; rom[3] = 19'h34567;
        rom[4] = 19'h45678; rom[5] = 19'h56789; rom[6] = 19'h6789a; rom[7] = 19'h0789b;
        do_start();
        watch(40);
        check("t3_n_issued", n_hs, 32'd7);
        for (int i = 0; i < 7; i++) check($sformatf("t3_pc%0d", i), {29'd0, hs_pc[i]}, i + 1);
        check("t3_last_word", {13'd0, hs_word[6]}, 32'h0789b);
        check("t3_no_addr0",  {31'd0, saw_addr0},  32'd0);
        check("t3_done_at",   done_at,             32'd14);
        check("t3_cnt",       {29'd0, issued_cnt}, 32'd7);
        tick();

        // End marker at the first address
        rom[1] = 19'h7f000;
        do_start();
        watch(10);
        check("t4_n_issued", n_hs, 32'd0);
        check("t4_done_at",  done_at, 32'd1);
        check("t4_cnt",      {29'd0, issued_cnt}, 32'd0);
        tick();

        // Flush during ISSUE of PC 2, with a stray start mid-run
        load_prog_main();
        do_start();           // E: FETCH pc1
        tick();               // E+1: ISSUE pc1
        tick();               // E+2: handshake, FETCH pc2
        start = 1'b1;
        tick();               // E+3: ISSUE pc2, start ignored
        start = 1'b0;
        check("t5_pc_after_start", {29'd0, inst_pc},    32'd2);
        check("t5_cnt_before",     {29'd0, issued_cnt}, 32'd1);
        check("t5_valid_before",   {31'd0, inst_valid}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_flush_busy",  {31'd0, busy},       32'd0);
        check("t5_flush_valid", {31'd0, inst_valid}, 32'd0);
        check("t5_flush_done",  {31'd0, done},       32'd0);
        check("t5_flush_cnt",   {29'd0, issued_cnt}, 32'd1);
        check("t5_flush_addr",  {29'd0, rom_addr},   32'd0);
        tick();
        check("t5_no_done_later", {31'd0, done}, 32'd0);
        check("t5_still_idle",    {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-ISSUE
        do_start();
        tick();
        tick();
        inst_ready = 1'b0;
        tick();
        check("t6_pre_valid", {31'd0, inst_valid}, 32'd1);
        check("t6_pre_cnt",   {29'd0, issued_cnt}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", {31'd0, inst_valid}, 32'd0);
        check("t6_rst_busy",  {31'd0, busy},       32'd0);
        check("t6_rst_done",  {31'd0, done},       32'd0);
        check("t6_rst_addr",  {29'd0, rom_addr},   32'd0);
        check("t6_rst_cnt",   {29'd0, issued_cnt}, 32'd0);
        check("t6_rst_pc",    {29'd0, inst_pc},    32'd0);
        check("t6_rst_instr", {13'd0, inst_op, inst_rd, inst_rs, inst_imm}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("t6_post_idle", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
